// File: rtl/spi_slave_rx.sv
// Receive-only SPI target: oversampled pins, MSB-first bytes,
// one-entry valid/ready holding register with overrun/frag status.
module spi_slave_rx #(
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_cs,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       overrun,
  input  logic       clr_overrun,
  output logic       frag
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    RESYNC = 2'd2
  } state_t;

  localparam bit RISE = (CPOL == CPHA);

  state_t     state;
  state_t     state_nxt;

  logic       cs_s1;
  logic       cs_s2;
  logic       cs_s3;
  logic       sclk_s1;
  logic       sclk_s2;
  logic       sclk_s3;
  logic       mosi_s1;
  logic       mosi_s2;

  logic [1:0] settle;
  logic       settled;
  logic [2:0] bitcnt;
  logic [2:0] cnt_nxt;
  logic [2:0] cnt_eff;
  logic [6:0] shreg;
  logic [7:0] byte_nxt;

  logic       sample;
  logic       cs_fall;
  logic       shift_en;
  logic       done;
  logic       take;
  logic       frag_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_s3   <= 1'b1;
      sclk_s1 <= CPOL;
      sclk_s2 <= CPOL;
      sclk_s3 <= CPOL;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      cs_s1   <= spi_cs;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
      sclk_s1 <= spi_clk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      mosi_s1 <= spi_mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  // cs_s2 only reflects the pin once two clocks have passed since reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      settle <= 2'd0;
    end else if (settle != 2'd2) begin
      settle <= settle + 2'd1;
    end
  end

  assign settled = (settle == 2'd2);

  assign sample  = RISE ? (sclk_s2 & ~sclk_s3)
                        : (~sclk_s2 & sclk_s3);
  assign cs_fall = cs_s3 & ~cs_s2;

  assign shift_en = (state == RECV) & sample;
  assign cnt_nxt  = bitcnt + 3'd1;
  assign cnt_eff  = shift_en ? cnt_nxt : bitcnt;
  assign done     = shift_en & (bitcnt == 3'd7);
  assign byte_nxt = {shreg, mosi_s2};
  assign take     = ~valid | ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RESYNC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nxt = RECV;
        end
      end
      RECV: begin
        if (cs_s2) begin
          state_nxt = IDLE;
        end
      end
      RESYNC: begin
        if (settled && cs_s2) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = RESYNC;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    frag_d = 1'b0;
    unique case (state)
      RECV: begin
        busy   = 1'b1;
        frag_d = cs_s2 & (cnt_eff != 3'd0);
      end
      default: begin
        busy   = 1'b0;
        frag_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bitcnt <= 3'd0;
      shreg  <= 7'd0;
    end else if (state != RECV) begin
      bitcnt <= 3'd0;
    end else if (shift_en) begin
      bitcnt <= cnt_nxt;
      shreg  <= byte_nxt[6:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data  <= 8'd0;
      valid <= 1'b0;
    end else if (done && take) begin
      data  <= byte_nxt;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

  // a drop on the same clock as a clear keeps the flag set
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (done && !take) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frag <= 1'b0;
    end else begin
      frag <= frag_d;
    end
  end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: all four SPI modes, scoreboarded bytes,
// overrun, fragment, reset-in-frame and same-clock handshake cases.
module tb_spi_slave_rx;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ready;
  logic       clr_overrun;
  logic       cs   [4];
  logic       sck  [4];
  logic       mosi [4];
  logic [7:0] data [4];
  logic       valid   [4];
  logic       busy    [4];
  logic       overrun [4];
  logic       frag    [4];

  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : g_dut
    spi_slave_rx #(
      .CPOL(m >= 2),
      .CPHA(m % 2 == 1)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .spi_cs     (cs[m]),
      .spi_clk    (sck[m]),
      .spi_mosi   (mosi[m]),
      .data       (data[m]),
      .valid      (valid[m]),
      .ready      (ready),
      .busy       (busy[m]),
      .overrun    (overrun[m]),
      .clr_overrun(clr_overrun),
      .frag       (frag[m])
    );
  end

  typedef struct packed {
    logic [1:0] m;
    logic [7:0] d;
  } exp_t;

  typedef struct {
    int          m;
    logic [23:0] bs;
    int          nb;
  } vec_t;

  exp_t       exp_q[$];
  logic [9:0] got [64];
  int         accepts  = 0;
  int         frag_cnt = 0;
  int         busy_cyc [4] = '{0, 0, 0, 0};
  int         rd     = 0;
  int         errors = 0;
  int         checks = 0;

  // monitor: record every byte handed over at the next posedge
  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (frag[m]) frag_cnt++;
      if (busy[m]) busy_cyc[m]++;
      if (valid[m] && ready && accepts < 64) begin
        got[accepts] = {2'(m), data[m]};
        accepts++;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input int m, input logic [7:0] d);
    exp_t e;
    e.m = 2'(m);
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic send_bits(input int m, input logic [7:0] b,
                           input int nbits);
    logic cpol;
    logic cpha;
    cpol = (m >= 2);
    cpha = (m % 2 == 1);
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) begin
        mosi[m] = b[i];
        tick(H);
        sck[m] = ~cpol;
        tick(H);
        sck[m] = cpol;
      end else begin
        sck[m]  = ~cpol;
        mosi[m] = b[i];
        tick(H);
        sck[m] = cpol;
        tick(H);
      end
    end
  endtask

  task automatic cs_low(input int m);
    cs[m] = 1'b0;
    tick(H);
  endtask

  task automatic cs_high(input int m);
    tick(H);
    cs[m] = 1'b1;
    tick(2 * H);
  endtask

  task automatic frame(input int m, input logic [23:0] bs,
                       input int nb);
    cs_low(m);
    for (int k = 0; k < nb; k++) send_bits(m, bs[23-8*k -: 8], 8);
    cs_high(m);
  endtask

  task automatic drain(input string nm);
    int   t;
    exp_t e;
    t = 0;
    while (accepts < rd + exp_q.size() && t < 400) begin
      @(negedge clk);
      t++;
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (rd < accepts) chk({nm, "_byte"}, 32'(got[rd]), 32'(e));
      else chk({nm, "_late"}, accepts, rd + 1);
      rd++;
    end
    tick(2);
    chk({nm, "_extra"}, accepts, rd);
  endtask

  vec_t tbl [6];
  int   acc0;
  int   frag0;
  int   bc0;

  initial begin
    tbl[0] = '{0, 24'hA50000, 1};
    tbl[1] = '{1, 24'hA50000, 1};
    tbl[2] = '{2, 24'hA50000, 1};
    tbl[3] = '{3, 24'hA50000, 1};
    tbl[4] = '{0, 24'h0180FF, 3};
    tbl[5] = '{3, 24'h5AC300, 2};

    rst_n       = 1'b0;
    ready       = 1'b1;
    clr_overrun = 1'b0;
    for (int m = 0; m < 4; m++) begin
      cs[m]   = 1'b1;
      sck[m]  = (m >= 2);
      mosi[m] = 1'b0;
    end
    tick(3);
    @(negedge clk);
    chk("rst_data", data[0], 8'h00);
    chk("rst_valid", valid[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_overrun", overrun[0], 0);
    chk("rst_frag", frag[0], 0);
    tick(1);
    rst_n = 1'b1;
    tick(4);

    for (int i = 0; i < 6; i++) begin
      acc0  = accepts;
      frag0 = frag_cnt;
      bc0   = busy_cyc[tbl[i].m];
      for (int k = 0; k < tbl[i].nb; k++)
        push(tbl[i].m, tbl[i].bs[23-8*k -: 8]);
      frame(tbl[i].m, tbl[i].bs, tbl[i].nb);
      drain($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_count", i), accepts - acc0, tbl[i].nb);
      chk($sformatf("vec%0d_busy_seen", i),
          32'(busy_cyc[tbl[i].m] > bc0), 1);
      chk($sformatf("vec%0d_busy_end", i), busy[tbl[i].m], 0);
      chk($sformatf("vec%0d_valid_end", i), valid[tbl[i].m], 0);
      chk($sformatf("vec%0d_overrun", i), overrun[tbl[i].m], 0);
      chk($sformatf("vec%0d_nofrag", i), frag_cnt - frag0, 0);
    end

    // held byte plus a dropped one
    ready = 1'b0;
    acc0  = accepts;
    frame(0, 24'h112200, 2);
    tick(4);
    @(negedge clk);
    chk("ovr_valid", valid[0], 1);
    chk("ovr_data", data[0], 8'h11);
    chk("ovr_flag", overrun[0], 1);
    chk("ovr_noaccept", accepts, acc0);
    push(0, 8'h11);
    tick(1);
    ready = 1'b1;
    drain("ovr");
    @(negedge clk);
    chk("ovr_valid_low", valid[0], 0);
    chk("ovr_data_hold", data[0], 8'h11);
    chk("ovr_sticky", overrun[0], 1);
    tick(1);
    clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0;
    @(negedge clk);
    chk("ovr_cleared", overrun[0], 0);

    // fragment of 5 bits
    tick(1);
    acc0  = accepts;
    frag0 = frag_cnt;
    cs_low(0);
    send_bits(0, 8'hC3, 5);
    cs_high(0);
    chk("frag_pulse", frag_cnt - frag0, 1);
    chk("frag_novalid", accepts, acc0);
    chk("frag_valid", valid[0], 0);
    push(0, 8'h3C);
    frame(0, 24'h3C0000, 1);
    drain("after_frag");

    // reset in mid-frame with CS held low
    acc0 = accepts;
    cs_low(0);
    send_bits(0, 8'hF0, 3);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    send_bits(0, 8'hAB, 4);
    @(negedge clk);
    chk("resync_busy", busy[0], 0);
    cs_high(0);
    chk("resync_nobytes", accepts, acc0);
    chk("resync_valid", valid[0], 0);
    chk("resync_frag", frag[0], 0);
    push(0, 8'h5A);
    frame(0, 24'h5A0000, 1);
    drain("after_resync");

    // ready lands on the clock the next byte completes
    ready = 1'b0;
    tick(1);
    push(0, 8'h77);
    cs_low(0);
    send_bits(0, 8'h77, 8);
    send_bits(0, 8'h88, 7);
    mosi[0] = 1'b0;
    tick(H);
    sck[0] = 1'b1;
    tick(1);
    tick(1);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    @(negedge clk);
    chk("same_clk_valid", valid[0], 1);
    chk("same_clk_data", data[0], 8'h88);
    chk("same_clk_overrun", overrun[0], 0);
    drain("same_clk_old");
    tick(1);
    sck[0] = 1'b0;
    cs_high(0);
    push(0, 8'h88);
    ready = 1'b1;
    drain("same_clk_new");
    chk("same_clk_overrun_end", overrun[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
